// File: rtl/memory_stage_if.sv
// memory_stage_if: EX/MEM inputs and MEM/WB outputs of the MEM stage.
//   master : execute side / bench (drives ex_*, observes mem_*)
//   slave  : memory_stage (consumes ex_*, drives mem_*)
interface memory_stage_if;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic [31:0] ex_ram_address;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_load_type;
  logic [2:0]  ex_store_type;
  logic        ex_misaligned;

  logic        mem_stall;
  logic [31:0] mem_wb_result;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_reg_write;
  logic        mem_wb_is_load;
  logic        mem_trap;
  logic [31:0] mem_trap_addr;

  modport master (
    output ex_valid, ex_result, ex_ram_address, ex_store_data, ex_rd, ex_reg_write,
           ex_is_load, ex_is_store, ex_load_type, ex_store_type, ex_misaligned,
    input  mem_stall, mem_wb_result, mem_wb_rd, mem_wb_reg_write, mem_wb_is_load,
           mem_trap, mem_trap_addr
  );

  modport slave (
    input  ex_valid, ex_result, ex_ram_address, ex_store_data, ex_rd, ex_reg_write,
           ex_is_load, ex_is_store, ex_load_type, ex_store_type, ex_misaligned,
    output mem_stall, mem_wb_result, mem_wb_rd, mem_wb_reg_write, mem_wb_is_load,
           mem_trap, mem_trap_addr
  );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the RV32 pipeline. Owns the byte-lane data RAM,
// performs LB/LH/LW/LBU/LHU and SB/SH/SW, and registers the MEM/WB slot.
// Ports:
//   clk   - core clock, rising edge
//   reset - synchronous, active-low
//   bus   - memory_stage_if.slave: ex_* from execute, mem_* to WB/forwarding
// Loads take one stall cycle (synchronous RAM read); faults trap until reset.
module memory_stage #(
  parameter int    ADDR_BITS = 9,
  parameter string INIT_FILE = ""
) (
  input  logic           clk,
  input  logic           reset,
  memory_stage_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, TRAP} state_t;
  localparam int DEPTH = 1 << ADDR_BITS;

  state_t state_q, state_d;

  logic [3:0][7:0] ram [DEPTH];
  logic [31:0]     rdata;

  logic [ADDR_BITS-1:0] widx;
  logic [1:0]           off;
  assign widx = bus.ex_ram_address[ADDR_BITS+1:2];  // upper bits ignored: address wraps
  assign off  = bus.ex_ram_address[1:0];

  logic            is_mem, fault, issue_load, do_store, stall;
  logic [3:0]      be;
  logic [3:0][7:0] wdata;
  logic [31:0]     ld_shift, ld_data;

  logic [1:0]  ld_off_q;
  logic [2:0]  ld_type_q;
  logic [4:0]  ld_rd_q;

  logic [31:0] wb_result_q, trap_addr_q;
  logic [4:0]  wb_rd_q;
  logic        wb_rw_q, wb_isl_q, trap_q;

  // access decode and fault detection
  always_comb begin
    is_mem = bus.ex_valid & (bus.ex_is_load | bus.ex_is_store);
    fault  = 1'b0;
    if (is_mem) begin
      if (bus.ex_misaligned || (bus.ex_is_load && bus.ex_is_store)) fault = 1'b1;
      else if (bus.ex_is_load) begin
        case (bus.ex_load_type)
          3'b000, 3'b100: fault = 1'b0;
          3'b001, 3'b101: fault = off[0];
          3'b010:         fault = |off;
          default:        fault = 1'b1;
        endcase
      end else begin
        case (bus.ex_store_type)
          3'b000:  fault = 1'b0;
          3'b001:  fault = off[0];
          3'b010:  fault = |off;
          default: fault = 1'b1;
        endcase
      end
    end
    issue_load = (state_q == IDLE) && is_mem && !fault && bus.ex_is_load;
    do_store   = (state_q == IDLE) && is_mem && !fault && bus.ex_is_store;
  end

  // store lane enables; data is replicated so each lane just picks its own byte
  always_comb begin
    be    = 4'b0000;
    wdata = {4{bus.ex_store_data[7:0]}};
    case (bus.ex_store_type)
      3'b000: be = 4'b0001 << off;
      3'b001: begin
        wdata = {2{bus.ex_store_data[15:0]}};
        be    = off[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        wdata = bus.ex_store_data;
        be    = 4'b1111;
      end
      default: be = 4'b0000;
    endcase
    if (!do_store) be = 4'b0000;
  end

  // RAM: no reset, contents survive core reset
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (be[l]) ram[widx][l] <= wdata[l];
    if (issue_load) rdata <= ram[widx];
  end

  always_ff @(posedge clk) begin
    if (issue_load) begin
      ld_off_q  <= off;
      ld_type_q <= bus.ex_load_type;
      ld_rd_q   <= bus.ex_rd;
    end
  end

  // load formatting from the latched offset/type
  always_comb begin
    ld_shift = rdata >> {ld_off_q, 3'b000};
    case (ld_type_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_data = {24'd0, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = rdata;
    endcase
  end

  // FSM
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem && fault) state_d = TRAP;
        else if (issue_load) begin
          state_d = LOAD_WAIT;
          stall   = 1'b1;
        end
      end
      LOAD_WAIT: state_d = IDLE;
      TRAP:      stall   = 1'b1;
      default:   state_d = IDLE;
    endcase
  end

  // MEM/WB register and trap capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_result_q <= '0;
      wb_rd_q     <= '0;
      wb_rw_q     <= 1'b0;
      wb_isl_q    <= 1'b0;
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wb_rw_q  <= 1'b0;
          wb_isl_q <= 1'b0;
          if (is_mem && fault) begin
            trap_q      <= 1'b1;
            trap_addr_q <= bus.ex_ram_address;
          end else if (bus.ex_valid && !is_mem) begin
            wb_result_q <= bus.ex_result;
            wb_rd_q     <= bus.ex_rd;
            wb_rw_q     <= bus.ex_reg_write;
          end
        end
        LOAD_WAIT: begin
          wb_result_q <= ld_data;
          wb_rd_q     <= ld_rd_q;
          wb_rw_q     <= |ld_rd_q;
          wb_isl_q    <= 1'b1;
        end
        default: begin
          wb_rw_q  <= 1'b0;
          wb_isl_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_stall        = stall;
  assign bus.mem_wb_result    = wb_result_q;
  assign bus.mem_wb_rd        = wb_rd_q;
  assign bus.mem_wb_reg_write = wb_rw_q;
  assign bus.mem_wb_is_load   = wb_isl_q;
  assign bus.mem_trap         = trap_q;
  assign bus.mem_trap_addr    = trap_addr_q;
endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_stage_if bus();
  memory_stage #(.ADDR_BITS(9), .INIT_FILE("")) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        valid, ld, st;
    logic [2:0]  ft;
    logic [31:0] addr, data, res;
    logic [4:0]  rd;
    logic        regw;
    logic [31:0] exp_res;
    logic        chk_res, exp_rw, exp_isl;
  } vec_t;

  vec_t        tbl[20];
  logic [31:0] mdl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic v, logic ld, logic st, logic [2:0] ft, logic [31:0] addr,
                              logic [31:0] data, logic [31:0] res, logic [4:0] rd, logic regw,
                              logic [31:0] eres, logic chkr, logic erw, logic eisl);
    vec_t t;
    t.valid = v; t.ld = ld; t.st = st; t.ft = ft; t.addr = addr; t.data = data;
    t.res = res; t.rd = rd; t.regw = regw; t.exp_res = eres; t.chk_res = chkr;
    t.exp_rw = erw; t.exp_isl = eisl;
    return t;
  endfunction

  task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] ft,
                       input logic [31:0] addr, input logic [31:0] data, input logic [31:0] res,
                       input logic [4:0] rd, input logic regw, input logic mis);
    bus.ex_valid = v; bus.ex_is_load = ld; bus.ex_is_store = st;
    bus.ex_load_type = ft; bus.ex_store_type = ft;
    bus.ex_ram_address = addr; bus.ex_store_data = data; bus.ex_result = res;
    bus.ex_rd = rd; bus.ex_reg_write = regw; bus.ex_misaligned = mis;
  endtask

  // called at posedge+1; returns at posedge+1 after the result is visible
  task automatic run_vec(input vec_t v, input string tag);
    drive(v.valid, v.ld, v.st, v.ft, v.addr, v.data, v.res, v.rd, v.regw, 1'b0);
    #1 chk({tag, " stall_issue"}, bus.mem_stall, v.valid && v.ld);
    @(posedge clk); #1;
    if (v.valid && v.ld) begin
      // this ALU op arrives during LOAD_WAIT and must be ignored
      drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, $urandom, 5'd31, 1'b1, 1'b0);
      #1 chk({tag, " stall_wait"}, bus.mem_stall, 1'b0);
      @(posedge clk); #1;
    end
    chk({tag, " reg_write"}, bus.mem_wb_reg_write, v.exp_rw);
    chk({tag, " is_load"}, bus.mem_wb_is_load, v.exp_isl);
    if (v.chk_res) begin
      chk({tag, " result"}, bus.mem_wb_result, v.exp_res);
      chk({tag, " rd"}, bus.mem_wb_rd, v.rd);
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " rst result"}, bus.mem_wb_result, 32'd0);
    chk({tag, " rst rd"}, bus.mem_wb_rd, 32'd0);
    chk({tag, " rst rw"}, bus.mem_wb_reg_write, 32'd0);
    chk({tag, " rst isl"}, bus.mem_wb_is_load, 32'd0);
    chk({tag, " rst trap"}, bus.mem_trap, 32'd0);
    chk({tag, " rst taddr"}, bus.mem_trap_addr, 32'd0);
    chk({tag, " rst stall"}, bus.mem_stall, 32'd0);
  endtask

  // reference model: word-granular array, stores/loads described by size/offset
  task automatic model_op(input int kind, input int w, input int o, input logic [2:0] ft,
                          input logic [31:0] data, input logic [4:0] rd, input logic regw);
    logic [31:0] r, addr, mask, val, sh, e;
    int          sx;
    vec_t        v;
    r    = $urandom;
    addr = {r[31:11], 5'b0, w[3:0], o[1:0]};
    case (kind)
      0: v = mk(1, 0, 0, ft, addr, data, data, rd, regw, data, 1, regw, 0);
      1: begin
        if (ft == 3'd0) begin mask = 32'hFF << (8 * o);   val = {4{data[7:0]}}; end
        else if (ft == 3'd1) begin mask = 32'hFFFF << (8 * o); val = {2{data[15:0]}}; end
        else begin mask = 32'hFFFFFFFF; val = data; end
        mdl[w] = (mdl[w] & ~mask) | (val & mask);
        v = mk(1, 0, 1, ft, addr, data, 32'd0, rd, regw, 32'd0, 0, 0, 0);
      end
      2: begin
        sh = mdl[w] >> (8 * o);
        case (ft)
          3'd0: begin sx = $signed(sh[7:0]);  e = sx; end
          3'd1: begin sx = $signed(sh[15:0]); e = sx; end
          3'd4: e = sh & 32'hFF;
          3'd5: e = sh & 32'hFFFF;
          default: e = mdl[w];
        endcase
        v = mk(1, 1, 0, ft, addr, 32'd0, 32'd0, rd, regw, e, 1, rd != 0, 1);
      end
      default: v = mk(0, 0, 0, ft, addr, data, data, rd, regw, 32'd0, 0, 0, 0);
    endcase
    run_vec(v, "rand");
  endtask

  initial begin
    logic [2:0] ltypes[5];
    logic [2:0] ft;
    int         kind, o;
    ltypes[0] = 3'd0; ltypes[1] = 3'd1; ltypes[2] = 3'd2; ltypes[3] = 3'd4; ltypes[4] = 3'd5;

    //             v ld st ft    addr          data          res       rd  rw exp           chk erw eisl
    tbl[0]  = mk(1, 0, 1, 3'd2, 32'h40,       32'hDEADBEEF, 32'd0,    0,  0, 32'd0,        0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 3'd2, 32'h40,       32'd0,        32'd0,    5,  1, 32'hDEADBEEF, 1, 1, 1);
    tbl[2]  = mk(1, 0, 1, 3'd0, 32'h41,       32'h00000080, 32'd0,    0,  0, 32'd0,        0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 3'd0, 32'h41,       32'd0,        32'd0,    6,  1, 32'hFFFFFF80, 1, 1, 1);
    tbl[4]  = mk(1, 1, 0, 3'd4, 32'h41,       32'd0,        32'd0,    6,  1, 32'h00000080, 1, 1, 1);
    tbl[5]  = mk(1, 1, 0, 3'd2, 32'h40,       32'd0,        32'd0,    7,  1, 32'hDEAD80EF, 1, 1, 1);
    tbl[6]  = mk(1, 0, 1, 3'd1, 32'h42,       32'h00008001, 32'd0,    0,  0, 32'd0,        0, 0, 0);
    tbl[7]  = mk(1, 1, 0, 3'd1, 32'h42,       32'd0,        32'd0,    8,  1, 32'hFFFF8001, 1, 1, 1);
    tbl[8]  = mk(1, 1, 0, 3'd5, 32'h42,       32'd0,        32'd0,    8,  1, 32'h00008001, 1, 1, 1);
    tbl[9]  = mk(1, 1, 0, 3'd0, 32'h43,       32'd0,        32'd0,    9,  1, 32'hFFFFFF80, 1, 1, 1);
    tbl[10] = mk(1, 1, 0, 3'd5, 32'h40,       32'd0,        32'd0,    9,  1, 32'h000080EF, 1, 1, 1);
    tbl[11] = mk(1, 1, 0, 3'd2, 32'h40,       32'd0,        32'd0,    0,  1, 32'h800180EF, 1, 0, 1);
    tbl[12] = mk(1, 0, 0, 3'd0, 32'h0,        32'd0,        32'h1234, 3,  1, 32'h1234,     1, 1, 0);
    tbl[13] = mk(0, 0, 0, 3'd0, 32'h0,        32'd0,        32'h9999, 4,  1, 32'd0,        0, 0, 0);
    tbl[14] = mk(1, 0, 0, 3'd0, 32'h0,        32'd0,        32'h5,    9,  0, 32'h5,        1, 0, 0);
    tbl[15] = mk(1, 0, 1, 3'd2, 32'h840,      32'h11223344, 32'd0,    0,  0, 32'd0,        0, 0, 0);
    tbl[16] = mk(1, 1, 0, 3'd2, 32'h40,       32'd0,        32'd0,    10, 1, 32'h11223344, 1, 1, 1);
    tbl[17] = mk(1, 0, 1, 3'd0, 32'h40,       32'h123456A5, 32'd0,    0,  0, 32'd0,        0, 0, 0);
    tbl[18] = mk(1, 1, 0, 3'd4, 32'hFFFFF840, 32'd0,        32'd0,    11, 1, 32'h000000A5, 1, 1, 1);
    tbl[19] = mk(1, 1, 0, 3'd1, 32'h40,       32'd0,        32'd0,    12, 1, 32'h000033A5, 1, 1, 1);

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk_reset_state("init");

    for (int i = 0; i < 20; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // randomized traffic against the model (words 0..15, random upper address bits)
    for (int w = 0; w < 16; w++) model_op(1, w, 0, 3'd2, $urandom, 5'd0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 3);
      if (kind == 1) begin
        ft = 3'($urandom_range(0, 2));
        o  = (ft == 3'd0) ? $urandom_range(0, 3) : (ft == 3'd1) ? 2 * $urandom_range(0, 1) : 0;
      end else if (kind == 2) begin
        ft = ltypes[$urandom_range(0, 4)];
        o  = (ft == 3'd0 || ft == 3'd4) ? $urandom_range(0, 3) :
             (ft == 3'd1 || ft == 3'd5) ? 2 * $urandom_range(0, 1) : 0;
      end else begin
        ft = 3'($urandom_range(0, 7));
        o  = $urandom_range(0, 3);
      end
      model_op(kind, $urandom_range(0, 15), o, ft, $urandom, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)));
    end

    // fault cases: each traps, holds stall, then clears on reset
    begin
      logic        fl[11], fs[11], fm[11];
      logic [2:0]  fft[11];
      logic [31:0] fa[11];
      fl = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
      fs = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
      fm = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
      fft = '{3'd5, 3'd2, 3'd1, 3'd0, 3'd3, 3'd6, 3'd1, 3'd2, 3'd2, 3'd3, 3'd2};
      fa = '{32'h43, 32'h42, 32'h41, 32'h40, 32'h40, 32'h40, 32'h41, 32'h42, 32'h40, 32'h40, 32'h40};
      for (int i = 0; i < 11; i++) begin
        drive(1'b1, fl[i], fs[i], fft[i], fa[i], 32'hFFFFFFFF, 32'd0, 5'd7, 1'b1, fm[i]);
        #1 chk($sformatf("flt%0d stall_idle", i), bus.mem_stall, 1'b0);
        @(posedge clk); #1;
        chk($sformatf("flt%0d trap", i), bus.mem_trap, 1'b1);
        chk($sformatf("flt%0d taddr", i), bus.mem_trap_addr, fa[i]);
        chk($sformatf("flt%0d rw", i), bus.mem_wb_reg_write, 1'b0);
        for (int c = 0; c < 3; c++) begin
          drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, $urandom, 5'd3, 1'b1, 1'b0);
          #1 chk($sformatf("flt%0d stall_hold", i), bus.mem_stall, 1'b1);
          @(posedge clk); #1;
          chk($sformatf("flt%0d rw_hold", i), bus.mem_wb_reg_write, 1'b0);
          chk($sformatf("flt%0d trap_hold", i), bus.mem_trap, 1'b1);
        end
        do_reset();
        chk_reset_state($sformatf("flt%0d", i));
      end
    end

    // faulting stores must not have touched word 0x40
    run_vec(mk(1, 1, 0, 3'd2, 32'h40, 32'd0, 32'd0, 13, 1, 32'h112233A5, 1, 1, 1), "post_flt");

    // reset during LOAD_WAIT aborts the load
    run_vec(mk(1, 0, 0, 3'd0, 32'd0, 32'd0, 32'hCAFE, 4, 1, 32'hCAFE, 1, 1, 0), "pre_abort");
    drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h40, 32'd0, 32'd0, 5'd14, 1'b1, 1'b0);
    #1 chk("abort stall_issue", bus.mem_stall, 1'b1);
    @(posedge clk); #1;
    do_reset();
    chk_reset_state("abort");
    @(posedge clk); #1;
    chk("abort no_wb", bus.mem_wb_reg_write, 1'b0);
    chk("abort no_isl", bus.mem_wb_is_load, 1'b0);
    run_vec(mk(1, 1, 0, 3'd2, 32'h40, 32'd0, 32'd0, 15, 1, 32'h112233A5, 1, 1, 1), "post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
